pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Consumes the load-use hazard signal (hazard_detection_src, 1 = proceed, 0 = stall) plus EX-stage branch resolution and data-memory handshake.
- Drives every pipeline-register enable and flush in the 5-stage RISC-V core.
- Adds a multi-cycle data-memory wait FSM with timeout detection and saturating performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.
- MEM_TIMEOUT, 64, consecutive MEM_WAIT cycles before timeout error; legal range 2..255.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- hazard_detection_src  input  1  1 = no load-use hazard, 0 = load-use stall request.
- EX_branch_taken  input  1  branch/jump in EX redirects the PC this cycle.
- MEM_mem_req  input  1  load or store occupies MEM.
- dmem_ready  input  1  data memory completes the access this cycle.
- pc_write  output  1  PC register load enable.
- IF_ID_write  output  1  IF/ID register load enable.
- IF_ID_flush  output  1  IF/ID becomes a NOP.
- ID_EX_write  output  1  ID/EX register load enable.
- ID_EX_flush  output  1  ID/EX control bits cleared, giving a bubble.
- EX_MEM_write  output  1  EX/MEM register load enable.
- MEM_WB_bubble  output  1  MEM/WB loads a bubble instead of MEM results.
- mem_timeout_err  output  1  sticky; set on timeout.
- stall_cycles  output  CNT_W  load-use stall cycle count.
- flush_count  output  CNT_W  branch flush event count.
- mem_wait_cycles  output  CNT_W  frozen memory-wait cycle count.

Behaviour:
- State machine: RUN, MEM_WAIT. Reset state is RUN. The state is 1 bit.
- freeze = MEM_mem_req & ~dmem_ready.
  - In RUN, freeze moves the state to MEM_WAIT at the next edge.
  - In MEM_WAIT, dmem_ready = 1 moves the state to RUN.
  - Freeze is evaluated combinationally in both states.
- Outputs are combinational from state and inputs. Priority, highest first:
  1. Reset (rst_n = 0): pc_write = IF_ID_write = ID_EX_write = EX_MEM_write = 0; IF_ID_flush = ID_EX_flush = MEM_WB_bubble = 1.
  2. Freeze: all *_write = 0, both flushes = 0, MEM_WB_bubble = 1.
  3. Branch (EX_branch_taken = 1): pc_write = 1, IF_ID_flush = 1, ID_EX_flush = 1, other writes = 1. The branch overrides a simultaneous load-use stall, because the stalled instruction is wrong-path.
  4. Load-use stall (hazard_detection_src = 0): pc_write = 0, IF_ID_write = 0, ID_EX_flush = 1, ID_EX_write = 1, EX_MEM_write = 1.
  5. Default: all writes = 1, flushes = 0, MEM_WB_bubble = 0.
- A branch in EX during freeze is held frozen. Its flush is applied only in the release cycle (dmem_ready = 1), exactly once.
- Wait counter (8 bits):
  - Clears on entering MEM_WAIT and in RUN.
  - Increments each MEM_WAIT cycle with dmem_ready = 0.
  - When it reaches MEM_TIMEOUT - 1 while dmem_ready = 0: mem_timeout_err is set and the state forces to RUN next cycle. The freeze is dropped only if the input condition clears.
  - mem_timeout_err is cleared only by reset.
- Perf counters increment at the edge after the qualifying cycle and saturate at all-ones (no wrap):
  - stall_cycles: priority-4 cycles.
  - flush_count: priority-3 cycles.
  - mem_wait_cycles: priority-2 cycles.
- Reset: state = RUN, wait counter = 0, all perf counters = 0, mem_timeout_err = 0. Reset asserted mid-MEM_WAIT returns to RUN on that edge, and outputs show priority 1 during reset.
- Latency: control outputs are zero-cycle (combinational). Counters and state are one cycle.

Decomposition:
- Package riscv_pipeline_pkg holds:
  - The state encoding (ST_RUN = 0, ST_MEM_WAIT = 1).
  - Default CNT_W and MEM_TIMEOUT constants.
- One sub-module, sat_counter (parameter W; ports clk, rst_n, inc, count), instantiated three times for the perf counters.

Test Plan:
- Reset held for 3 cycles with all inputs active: outputs equal priority-1 values every cycle; after release, counters = 0, err = 0, state = RUN.
- hazard_detection_src = 0 for 1 cycle, otherwise idle: pc_write = 0, IF_ID_write = 0, ID_EX_flush = 1 that cycle; stall_cycles = 1 next cycle.
- EX_branch_taken = 1 with hazard_detection_src = 0 in the same cycle: pc_write = 1, IF_ID_flush = 1, ID_EX_flush = 1; flush_count = 1, stall_cycles unchanged.
- MEM_mem_req = 1, dmem_ready = 0 for 5 cycles then 1, with EX_branch_taken held 1 throughout:
  - The 5 cycles show all writes = 0, MEM_WB_bubble = 1, no flush.
  - The release cycle shows the flush.
  - mem_wait_cycles = 5, flush_count = 1.
- MEM_TIMEOUT = 4, dmem_ready held at 0: mem_timeout_err rises after the 4th wait cycle and stays 1 until rst_n = 0.
- CNT_W = 3, hazard_detection_src = 0 for 10 cycles: stall_cycles saturates at 7.

Source files
------------

// File: rtl/riscv_pipeline_pkg.sv
// Shared definitions for the pipeline stall controller.
//   state_e          : 1-bit stall-controller state (RUN / MEM_WAIT)
//   DEF_CNT_W        : default performance-counter width
//   DEF_MEM_TIMEOUT  : default memory-wait timeout in MEM_WAIT cycles
//   WAIT_CNT_W       : width of the memory-wait cycle counter
package riscv_pipeline_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    localparam int unsigned DEF_CNT_W       = 32;
    localparam int unsigned DEF_MEM_TIMEOUT = 64;
    localparam int unsigned WAIT_CNT_W      = 8;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the stall-controller performance counters.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, clears the count
//   inc   : count this cycle (ignored once the count is all-ones)
//   count : current count value
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline enable/flush controller for the 5-stage RISC-V core.
// Combines load-use hazard, EX branch redirect and data-memory wait into the
// pipeline-register enables/flushes, tracks a memory-wait timeout and keeps
// saturating performance counters.
//   Inputs : clk, rst_n (sync, active low), hazard_detection_src (0 = stall),
//            EX_branch_taken, MEM_mem_req, dmem_ready
//   Outputs: pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
//            EX_MEM_write, MEM_WB_bubble, mem_timeout_err (sticky),
//            stall_cycles, flush_count, mem_wait_cycles (CNT_W each)
module pipeline_stall_controller
    import riscv_pipeline_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_detection_src,
    input  logic             EX_branch_taken,
    input  logic             MEM_mem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_write,
    output logic             ID_EX_flush,
    output logic             EX_MEM_write,
    output logic             MEM_WB_bubble,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] mem_wait_cycles
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    err_q, err_d;

    logic freeze;
    logic timeout_hit;
    logic stall_inc, flush_inc, wait_inc;

    assign freeze      = MEM_mem_req & ~dmem_ready;
    assign timeout_hit = (state_q == ST_MEM_WAIT) && !dmem_ready
                         && (wait_cnt_q == TIMEOUT_LAST);

    // State register plus wait counter and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    // Next state. A timeout forces RUN; if the request is still pending the
    // freeze re-enters MEM_WAIT on the following edge.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        err_d      = err_q | timeout_hit;
        unique case (state_q)
            ST_RUN: begin
                if (freeze) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready || timeout_hit) begin
                    state_d = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Outputs by priority: reset, freeze, branch, load-use stall, default.
    // A branch held during freeze only flushes in the release cycle, since
    // dmem_ready = 1 removes the freeze.
    always_comb begin
        pc_write      = 1'b1;
        IF_ID_write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_write   = 1'b1;
        ID_EX_flush   = 1'b0;
        EX_MEM_write  = 1'b1;
        MEM_WB_bubble = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        wait_inc      = 1'b0;
        if (!rst_n) begin
            pc_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_write   = 1'b0;
            EX_MEM_write  = 1'b0;
            IF_ID_flush   = 1'b1;
            ID_EX_flush   = 1'b1;
            MEM_WB_bubble = 1'b1;
        end else if (freeze) begin
            pc_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_write   = 1'b0;
            EX_MEM_write  = 1'b0;
            MEM_WB_bubble = 1'b1;
            wait_inc      = 1'b1;
        end else if (EX_branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            flush_inc   = 1'b1;
        end else if (!hazard_detection_src) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            stall_inc   = 1'b1;
        end
    end

    assign mem_timeout_err = err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_count)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wait_inc),
        .count (mem_wait_cycles)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;
    import riscv_pipeline_pkg::*;

    // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_write, MEM_WB_bubble}
    localparam logic [6:0] P_RESET  = 7'b0010101;
    localparam logic [6:0] P_FREEZE = 7'b0000001;
    localparam logic [6:0] P_BRANCH = 7'b1111110;
    localparam logic [6:0] P_STALL  = 7'b0001110;
    localparam logic [6:0] P_IDLE   = 7'b1101010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_m, rst_t, rst_s;
    logic hz, br, req, rdy;

    int checks   = 0;
    int failures = 0;

    // main instance: default parameters
    logic pcw_m, ifw_m, iff_m, idw_m, idf_m, exw_m, bub_m, err_m;
    logic [31:0] stall_m, flush_m, wait_m;
    logic [6:0] ctl_m;
    assign ctl_m = {pcw_m, ifw_m, iff_m, idw_m, idf_m, exw_m, bub_m};

    pipeline_stall_controller dut (
        .clk(clk), .rst_n(rst_m), .hazard_detection_src(hz), .EX_branch_taken(br),
        .MEM_mem_req(req), .dmem_ready(rdy),
        .pc_write(pcw_m), .IF_ID_write(ifw_m), .IF_ID_flush(iff_m), .ID_EX_write(idw_m),
        .ID_EX_flush(idf_m), .EX_MEM_write(exw_m), .MEM_WB_bubble(bub_m),
        .mem_timeout_err(err_m), .stall_cycles(stall_m), .flush_count(flush_m),
        .mem_wait_cycles(wait_m)
    );

    // timeout instance: MEM_TIMEOUT = 4
    logic pcw_t, ifw_t, iff_t, idw_t, idf_t, exw_t, bub_t, err_t;
    logic [31:0] stall_t, flush_t, wait_t;
    logic [6:0] ctl_t;
    assign ctl_t = {pcw_t, ifw_t, iff_t, idw_t, idf_t, exw_t, bub_t};

    pipeline_stall_controller #(.MEM_TIMEOUT(4)) dut_t (
        .clk(clk), .rst_n(rst_t), .hazard_detection_src(hz), .EX_branch_taken(br),
        .MEM_mem_req(req), .dmem_ready(rdy),
        .pc_write(pcw_t), .IF_ID_write(ifw_t), .IF_ID_flush(iff_t), .ID_EX_write(idw_t),
        .ID_EX_flush(idf_t), .EX_MEM_write(exw_t), .MEM_WB_bubble(bub_t),
        .mem_timeout_err(err_t), .stall_cycles(stall_t), .flush_count(flush_t),
        .mem_wait_cycles(wait_t)
    );

    // saturation instance: CNT_W = 3
    logic pcw_s, ifw_s, iff_s, idw_s, idf_s, exw_s, bub_s, err_s;
    logic [2:0] stall_s, flush_s, wait_s;

    pipeline_stall_controller #(.CNT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_s), .hazard_detection_src(hz), .EX_branch_taken(br),
        .MEM_mem_req(req), .dmem_ready(rdy),
        .pc_write(pcw_s), .IF_ID_write(ifw_s), .IF_ID_flush(iff_s), .ID_EX_write(idw_s),
        .ID_EX_flush(idf_s), .EX_MEM_write(exw_s), .MEM_WB_bubble(bub_s),
        .mem_timeout_err(err_s), .stall_cycles(stall_s), .flush_count(flush_s),
        .mem_wait_cycles(wait_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic h, input logic b, input logic r, input logic d);
        hz  = h;
        br  = b;
        req = r;
        rdy = d;
    endtask

    // Registered results are settled 2 time units after the rising edge.
    task automatic next();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_m = 1'b0;
        rst_t = 1'b0;
        rst_s = 1'b0;
        set_in(1'b0, 1'b1, 1'b1, 1'b0);

        // reset with every input active
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("reset_ctl", 32'(ctl_m), 32'(P_RESET));
            next();
        end

        rst_m = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_stall_cnt", stall_m, 32'd0);
        chk("rst_flush_cnt", flush_m, 32'd0);
        chk("rst_wait_cnt", wait_m, 32'd0);
        chk("rst_err", 32'(err_m), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(ST_RUN));
        #1;
        chk("idle_ctl", 32'(ctl_m), 32'(P_IDLE));
        next();

        // single load-use stall
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("stall_ctl", 32'(ctl_m), 32'(P_STALL));
        next();
        chk("stall_cnt_1", stall_m, 32'd1);
        chk("stall_no_flush", flush_m, 32'd0);

        // branch overrides simultaneous stall
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("branch_ctl", 32'(ctl_m), 32'(P_BRANCH));
        next();
        chk("branch_flush_cnt", flush_m, 32'd1);
        chk("branch_stall_keep", stall_m, 32'd1);

        // memory wait of 5 cycles with a branch held in EX
        set_in(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("freeze_ctl", 32'(ctl_m), 32'(P_FREEZE));
            next();
        end
        chk("freeze_state", 32'(dut.state_q), 32'(ST_MEM_WAIT));
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        chk("release_ctl", 32'(ctl_m), 32'(P_BRANCH));
        next();
        chk("mem_wait_cnt", wait_m, 32'd5);
        // one flush from the earlier branch test plus the release flush
        chk("release_flush_cnt", flush_m, 32'd2);
        chk("release_state", 32'(dut.state_q), 32'(ST_RUN));
        chk("no_timeout_main", 32'(err_m), 32'd0);
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        next();

        // timeout with MEM_TIMEOUT = 4: one RUN freeze cycle plus four MEM_WAIT cycles
        rst_t = 1'b1;
        set_in(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            next();
            chk("timeout_err", 32'(err_t), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("timeout_forces_run", 32'(dut_t.state_q), 32'(ST_RUN));
        for (int i = 0; i < 3; i++) begin
            next();
            chk("timeout_sticky", 32'(err_t), 32'd1);
        end
        chk("rewait_state", 32'(dut_t.state_q), 32'(ST_MEM_WAIT));
        rst_t = 1'b0;
        #1;
        chk("reset_mid_wait_ctl", 32'(ctl_t), 32'(P_RESET));
        next();
        chk("reset_clears_err", 32'(err_t), 32'd0);
        chk("reset_mid_wait_state", 32'(dut_t.state_q), 32'(ST_RUN));

        // saturation with CNT_W = 3
        rst_s = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            next();
            chk("stall_sat", 32'(stall_s), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
